// File: rtl/cfg_bus_pkg.sv
// Shared types for the configuration-bus master: opcodes, FSM states and
// the command record carried through the command queue.
package cfg_bus_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BUS_ADDR_W = 32;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_POLL    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_RESP
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] mask;
    } cmd_t;

    // POLL compares only the masked bits of the read value and the expected value.
    function automatic logic poll_match(input cmd_t c, input logic [DATA_W-1:0] rdata);
        return (rdata & c.mask) == (c.wdata & c.mask);
    endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Command queue: DEPTH-entry FIFO of cmd_t with registered full/empty flags.
// A push while full is dropped; a pop while empty is ignored.
module cfg_cmd_fifo
    import cfg_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t push_data_i,
    input  logic pop_i,
    output cmd_t head_o,
    output logic full_o,
    output logic empty_o,
    output logic empty_nxt_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             wr_en, rd_en;

    assign wr_en       = push_i && !full_q;
    assign rd_en       = pop_i && !empty_q;
    assign head_o      = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign empty_nxt_c = (cnt_d == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cfg_bus_master.sv
// Configuration-bus master: queues WRITE/READ/POLL commands and executes them
// one at a time on a single-cycle strobe register bus, returning one response each.
module cfg_bus_master
    import cfg_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TO_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W-1:0]     cmd_mask,
    input  logic [TO_W-1:0]       poll_max,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [BUS_ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0]     cfg_wdata,
    output logic                  cfg_we,
    output logic                  cfg_re,
    input  logic [DATA_W-1:0]     cfg_rdata,
    output logic                  busy
);

    state_e                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [TO_W-1:0]       att_q, att_d, att_inc, poll_lim;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [BUS_ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
    logic [DATA_W-1:0]     cfg_wdata_q, cfg_wdata_d;
    logic                  cfg_we_q, cfg_we_d;
    logic                  cfg_re_q, cfg_re_d;
    logic                  busy_q, busy_d;

    cmd_t fifo_wdata, fifo_head;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_empty_nxt;

    always_comb begin
        fifo_wdata.op    = op_e'(cmd_op);
        fifo_wdata.addr  = cmd_addr;
        fifo_wdata.wdata = cmd_wdata;
        fifo_wdata.mask  = cmd_mask;
    end

    assign fifo_push = cmd_valid && !fifo_full;

    cfg_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt)
    );

    // A poll limit of zero still allows one attempt; the counter saturates.
    assign poll_lim = (poll_max == '0) ? TO_W'(1) : poll_max;
    assign att_inc  = (&att_q) ? att_q : att_q + TO_W'(1);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        att_d       = att_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    att_d    = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (cmd_q.op)
                    OP_WRITE: begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                    OP_READ, OP_POLL: begin
                        state_d = ST_WAIT_RD;
                    end
                    OP_ILLEGAL: begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end
                endcase
            end
            ST_WAIT_RD: begin
                rsp_rdata_d = cfg_rdata;
                rsp_err_d   = 1'b0;
                if (cmd_q.op != OP_POLL || poll_match(cmd_q, cfg_rdata)) begin
                    state_d = ST_RESP;
                end else begin
                    att_d = att_inc;
                    if (att_inc >= poll_lim) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
        endcase

        // Bus and response outputs are registered from the upcoming state.
        cfg_we_d    = (state_d == ST_ISSUE) && (cmd_d.op == OP_WRITE);
        cfg_re_d    = (state_d == ST_ISSUE) && (cmd_d.op == OP_READ || cmd_d.op == OP_POLL);
        cfg_addr_d  = (cfg_we_d || cfg_re_d) ? BUS_ADDR_W'(cmd_d.addr) : '0;
        cfg_wdata_d = cfg_we_d ? cmd_d.wdata : '0;
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE) || !fifo_empty_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            att_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            cfg_we_q    <= 1'b0;
            cfg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            att_q       <= att_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_we_q    <= cfg_we_d;
            cfg_re_q    <= cfg_re_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign cfg_we    = cfg_we_q;
    assign cfg_re    = cfg_re_q;
    assign busy      = busy_q;

endmodule
